alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_seq_muldiv.sv | 116 +++++++++++
 rtl/alu_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Opcodes, FSM states and the signed-minimum helper.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Most negative two's complement value of a w-bit word.
    function automatic logic [63:0] signed_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative signed multiply (shift-add) and divide (restoring).
// Works on magnitudes; the sign is applied to the final value.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN = WIDTH'(signed_min(WIDTH));

    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mag_b;
    logic             neg;
    logic             div_q;
    logic             b_zero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_s;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     prod_top;
    logic [WIDTH-1:0]   quo_sg;

    assign a_mag = data_a[WIDTH-1] ? -data_a : data_a;
    assign b_mag = data_b[WIDTH-1] ? -data_b : data_b;

    // One multiply or divide step on the {hi,lo} pair.
    always_comb begin
        hi_d  = hi;
        lo_d  = lo;
        sum   = hi + (lo[0] ? {1'b0, mag_b} : '0);
        rem_s = {hi[WIDTH-1:0], lo[WIDTH-1]};
        quo_s = {lo[WIDTH-2:0], 1'b0};
        trial = rem_s - {1'b0, mag_b};
        if (div_q) begin
            if (!trial[WIDTH]) begin
                hi_d = trial;
                lo_d = quo_s | WIDTH'(1);
            end else begin
                hi_d = rem_s;
                lo_d = quo_s;
            end
        end else begin
            hi_d = {1'b0, sum[WIDTH:1]};
            lo_d = {sum[0], lo[WIDTH-1:1]};
        end
    end

    // Operand capture on start, then one step per cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            mag_b  <= '0;
            neg    <= 1'b0;
            div_q  <= 1'b0;
            b_zero <= 1'b0;
        end else if (start) begin
            cnt    <= CW'(WIDTH);
            hi     <= '0;
            lo     <= op_div ? a_mag : b_mag;
            mag_b  <= op_div ? b_mag : a_mag;
            neg    <= data_a[WIDTH-1] ^ data_b[WIDTH-1];
            div_q  <= op_div;
            b_zero <= (data_b == '0);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            hi  <= hi_d;
            lo  <= lo_d;
        end
    end

    // Sign fix-up and overflow detection on the finished value.
    always_comb begin
        prod     = {hi[WIDTH-1:0], lo};
        prod_s   = neg ? -prod : prod;
        prod_top = prod_s[2*WIDTH-1:WIDTH-1];
        quo_sg   = neg ? -lo : lo;
        result   = '0;
        ovf      = 1'b0;
        dbz      = 1'b0;
        if (div_q) begin
            dbz    = b_zero;
            result = b_zero ? '0 : quo_sg;
            ovf    = !b_zero && !neg && (lo == MIN);
        end else begin
            result = prod_s[WIDTH-1:0];
            ovf    = !((&prod_top) || !(|prod_top));
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and held result.
// Single-cycle ops plus iterative signed multiply/divide.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             exception
);

    state_t state;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [4:0]       op_q;
    logic [SHW-1:0]   sh_q;

    logic accept;
    logic start;
    logic is_md;
    logic wr_en;

    logic             md_done;
    logic [WIDTH-1:0] md_res;
    logic             md_ovf;
    logic             md_dbz;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;
    logic             exc_d;

    assign accept = (state == IDLE) && in_valid;
    assign start  = accept && (ctrl_ALUopcode == OP_MUL ||
                               ctrl_ALUopcode == OP_DIV);
    assign is_md  = (op_q == OP_MUL) || (op_q == OP_DIV);

    muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op_div  (ctrl_ALUopcode == OP_DIV),
        .data_a  (data_operandA),
        .data_b  (data_operandB),
        .done    (md_done),
        .result  (md_res),
        .ovf     (md_ovf),
        .dbz     (md_dbz)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next state; single-cycle ops spend one evaluation cycle in BUSY.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (in_valid) state_d = BUSY;
            BUSY: if (!is_md || md_done) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign wr_en     = (state == BUSY) && (state_d == DONE);

    // Request capture on the accept edge only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            sh_q <= '0;
        end else if (accept) begin
            a_q  <= data_operandA;
            b_q  <= data_operandB;
            op_q <= ctrl_ALUopcode;
            sh_q <= ctrl_shiftamt;
        end
    end

    assign sum     = a_q + b_q;
    assign diff    = a_q - b_q;
    assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (sum[WIDTH-1] != a_q[WIDTH-1]);
    assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                     (diff[WIDTH-1] != a_q[WIDTH-1]);

    // Result, overflow and exception selection by latched opcode.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        exc_d = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_d = sum;
                ovf_d = add_ovf;
            end
            OP_SUB: begin
                res_d = diff;
                ovf_d = sub_ovf;
            end
            OP_AND: res_d = a_q & b_q;
            OP_OR:  res_d = a_q | b_q;
            OP_SLL: res_d = a_q << sh_q;
            OP_SRA: res_d = $unsigned($signed(a_q) >>> sh_q);
            OP_MUL: begin
                res_d = md_res;
                ovf_d = md_ovf;
            end
            OP_DIV: begin
                res_d = md_res;
                ovf_d = md_ovf;
                exc_d = md_dbz;
            end
            default: exc_d = 1'b1;
        endcase
    end

    // Output registers, loaded only when entering DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result <= '0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
            exception   <= 1'b0;
        end else if (wr_en) begin
            data_result <= res_d;
            isNotEqual  <= |diff;
            isLessThan  <= diff[WIDTH-1] ^ sub_ovf;
            overflow    <= ovf_d;
            exception   <= exc_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors, queued expectations,
// independent monitor comparing each presented result.
module tb_alu_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  opc = '0;
    logic [4:0]  sh = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] res;
    logic        ne, lt, ovf, exc;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [4:0]  opc8 = '0;
    logic [2:0]  sh8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  res8;
    logic        ne8, lt8, ovf8, exc8;

    alu_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(a), .data_operandB(b),
        .ctrl_ALUopcode(opc), .ctrl_shiftamt(sh),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_result(res), .isNotEqual(ne), .isLessThan(lt),
        .overflow(ovf), .exception(exc)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .data_operandA(a8), .data_operandB(b8),
        .ctrl_ALUopcode(opc8), .ctrl_shiftamt(sh8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .data_result(res8), .isNotEqual(ne8), .isLessThan(lt8),
        .overflow(ovf8), .exception(exc8)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] r;
        logic        e_ne;
        logic        e_lt;
        logic        e_ov;
        logic        e_ex;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   seen = 0;
    logic [31:0] held;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Cycle counter and accept-edge recorder.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset_n && in_valid && in_ready) acc_q.push_back(cyc);
    end

    // Monitor: checks each new result and its stability while held.
    always @(negedge clock) begin
        if (!reset_n) begin
            seen = 0;
        end else if (out_valid && !seen) begin
            seen = 1;
            held = res;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: got %h want none", res);
            end else begin
                exp_t e;
                int   ac;
                e  = exp_q.pop_front();
                ac = acc_q.pop_front();
                n_vec++;
                chk($sformatf("v%0d result", n_vec), res, e.r);
                chk($sformatf("v%0d isNotEqual", n_vec), 32'(ne), 32'(e.e_ne));
                chk($sformatf("v%0d isLessThan", n_vec), 32'(lt), 32'(e.e_lt));
                chk($sformatf("v%0d overflow", n_vec), 32'(ovf), 32'(e.e_ov));
                chk($sformatf("v%0d exception", n_vec), 32'(exc), 32'(e.e_ex));
                chk($sformatf("v%0d latency", n_vec), 32'(cyc - ac), 32'(e.lat));
            end
        end else if (out_valid && seen) begin
            chk("hold result", res, held);
            chk("hold in_ready", 32'(in_ready), 32'd0);
        end else if (!out_valid) begin
            seen = 0;
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input logic [4:0] s,
                         input logic [31:0] r, input logic e_ne,
                         input logic e_lt, input logic e_ov,
                         input logic e_ex, input int lat, input bit push);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL issue_timeout: in_ready got 0 want 1");
        end else begin
            opc = op; a = va; b = vb; sh = s;
            in_valid = 1'b1;
            if (push) exp_q.push_back('{r, e_ne, e_lt, e_ov, e_ex, lat});
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            a = $urandom;
            b = $urandom;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++)
            @(negedge clock);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: pending got %0d want 0",
                     exp_q.size());
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    task automatic run8(input logic [4:0] op, input logic [7:0] va,
                        input logic [7:0] vb, input logic [7:0] r,
                        input logic e_ov, input logic e_ex,
                        input int lat);
        int c;
        @(negedge clock);
        opc8 = op; a8 = va; b8 = vb; in_valid8 = 1'b1;
        @(posedge clock);
        #1;
        in_valid8 = 1'b0;
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (out_valid8) begin
                c = i;
                break;
            end
        end
        n_vec++;
        chk("w8 latency", 32'(c), 32'(lat));
        chk("w8 result", 32'(res8), 32'(r));
        chk("w8 overflow", 32'(ovf8), 32'(e_ov));
        chk("w8 exception", 32'(exc8), 32'(e_ex));
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time got %0t want < 1000000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clock);
        n_vec++;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", res, 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;

        issue(5'd0, 32'h7FFFFFFF, 32'h1, 5'd0,
              32'h80000000, 1, 0, 1, 0, 1, 1);
        issue(5'd1, 32'd5, 32'd7, 5'd0,
              32'hFFFFFFFE, 1, 1, 0, 0, 1, 1);
        issue(5'd1, 32'h80000000, 32'h1, 5'd0,
              32'h7FFFFFFF, 1, 1, 1, 0, 1, 1);
        drain();

        // mul in flight, reset at iteration 5
        issue(5'd6, 32'd100, 32'd3, 5'd0, 32'd0, 0, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        acc_q.delete();
        n_vec++;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst result", res, 32'd0);
        chk("rst flags", {28'd0, ne, lt, ovf, exc}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clock);
        chk("rst no_output", 32'(out_valid), 32'd0);

        issue(5'd0, 32'd3, 32'd4, 5'd0, 32'd7, 1, 1, 0, 0, 1, 1);
        issue(5'd6, -32'sd6, 32'd7, 5'd0,
              32'hFFFFFFD6, 1, 1, 0, 0, 33, 1);
        issue(5'd6, 32'h10000, 32'h10000, 5'd0,
              32'h0, 0, 0, 1, 0, 33, 1);
        issue(5'd7, -32'sd7, 32'd2, 5'd0,
              32'hFFFFFFFD, 1, 1, 0, 0, 33, 1);
        issue(5'd7, 32'd9, 32'd0, 5'd0,
              32'h0, 1, 0, 0, 1, 33, 1);
        issue(5'd7, 32'h80000000, 32'hFFFFFFFF, 5'd0,
              32'h80000000, 1, 1, 1, 0, 33, 1);
        issue(5'd5, 32'h80000000, 32'd0, 5'd31,
              32'hFFFFFFFF, 1, 1, 0, 0, 1, 1);
        issue(5'd4, 32'd1, 32'd0, 5'd31,
              32'h80000000, 1, 0, 0, 0, 1, 1);
        issue(5'd2, 32'h0000F0F0, 32'h0000FF00, 5'd0,
              32'h0000F000, 1, 1, 0, 0, 1, 1);
        issue(5'd3, 32'h0000F0F0, 32'h0000FF00, 5'd0,
              32'h0000FFF0, 1, 1, 0, 0, 1, 1);
        issue(5'd9, 32'd5, 32'd5, 5'd0, 32'h0, 0, 0, 0, 1, 1, 1);
        drain();

        // backpressure with a competing request
        out_ready = 1'b0;
        issue(5'd0, 32'h10, 32'h20, 5'd0, 32'h30, 1, 1, 0, 0, 1, 1);
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clock);
        opc = 5'd0; a = 32'd1; b = 32'd1;
        in_valid = 1'b1;
        repeat (10) @(negedge clock);
        n_vec++;
        chk("bp out_valid", 32'(out_valid), 32'd1);
        chk("bp result", res, 32'h30);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (5) @(negedge clock);

        run8(5'd6, 8'h0F, 8'h03, 8'h2D, 0, 0, 9);
        run8(5'h1F, 8'h12, 8'h34, 8'h00, 0, 1, 1);

        chk("final queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
